// File: rtl/bitstream_density_pkg.sv
// Shared definitions for the bitstream density meter: FSM state encoding,
// default result width and the full-scale probability value (2**16 == "always 1").
// Optional feature macro used by the top level: DENSITY_METER_CONTINUOUS_EN.
package bitstream_density_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  localparam int PROB_W_DEFAULT = 32'sd17;
  localparam int FULL_SCALE     = 32'sd65536;

endpackage

// File: rtl/bitstream_density_meter_tick_window_counter.sv
// Window tick counter for the density meter. Counts qualified sample ticks and
// flags the last tick position of the window. A clear that coincides with a tick
// starts the new window already holding that tick, so back-to-back windows lose
// nothing.
module tick_window_counter #(
  parameter int WIDTH = 16
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic clear_i,
  input  logic tick_i,
  output logic terminal_o
);

  logic [WIDTH-1:0] tick_cnt_r;

  // Tick counter: reset, clear (optionally seeding the coincident tick), or count.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      tick_cnt_r <= {WIDTH{1'b0}};
    end else if (clear_i) begin
      tick_cnt_r <= WIDTH'(tick_i);
    end else if (tick_i) begin
      tick_cnt_r <= tick_cnt_r + WIDTH'(1'b1);
    end else begin
      tick_cnt_r <= tick_cnt_r;
    end
  end

  // Terminal count: the next counted tick closes the window.
  always_comb begin
    terminal_o = (tick_cnt_r == {WIDTH{1'b1}});
  end

endmodule

// File: rtl/bitstream_density_meter.sv
// Bitstream density meter: measures the fraction of ones in a sampled bitstream
// over a window of 2**WINDOW_LOG2 sample ticks and reports it in probability
// units where 2**16 means "always 1".
// Optional macro DENSITY_METER_CONTINUOUS_EN: windows run back-to-back after a
// single start; without it every measurement needs its own start_i.
module bitstream_density_meter
  import bitstream_density_pkg::*;
#(
  parameter int WINDOW_LOG2 = 16,
  parameter int PROB_W      = PROB_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              sample_tick_i,
  input  logic              bit_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic [PROB_W-1:0] density_o,
  output logic              density_valid_o
);

  localparam int ONES_W = WINDOW_LOG2 + 1;
  localparam int SHIFT  = $clog2(FULL_SCALE) - WINDOW_LOG2;

  state_e              state_r;
  state_e              state_next_s;
  logic                clear_s;
  logic                tick_en_s;
  logic                tick_s;
  logic                terminal_s;
  logic [ONES_W-1:0]   ones_cnt_r;
  logic [ONES_W-1:0]   ones_inc_s;
  logic [ONES_W-1:0]   ones_sum_s;
  logic [PROB_W-1:0]   density_calc_s;
  logic                busy_r;
  logic [PROB_W-1:0]   density_r;
  logic                density_valid_r;

  tick_window_counter #(
    .WIDTH (WINDOW_LOG2)
  ) u_tick_window_counter (
    .clk_i      (clk_i),
    .srst_i     (srst_i),
    .clear_i    (clear_s),
    .tick_i     (tick_s),
    .terminal_o (terminal_s)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic plus counter clear/enable strobes.
  always_comb begin
    state_next_s = state_r;
    clear_s      = 1'b0;
    tick_en_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_next_s = ST_COUNT;
          clear_s      = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_COUNT: begin
        tick_en_s = 1'b1;
        if (sample_tick_i && terminal_s) begin
          state_next_s = ST_REPORT;
        end else begin
          state_next_s = ST_COUNT;
        end
      end
      ST_REPORT: begin
`ifdef DENSITY_METER_CONTINUOUS_EN
        // Restart immediately; a tick in this cycle belongs to the new window.
        state_next_s = ST_COUNT;
        clear_s      = 1'b1;
        tick_en_s    = 1'b1;
`else
        state_next_s = ST_IDLE;
`endif
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Qualified tick, ones increment and the density the window would report now.
  always_comb begin
    tick_s         = tick_en_s & sample_tick_i;
    ones_inc_s     = ONES_W'(bit_i & tick_s);
    ones_sum_s     = ones_cnt_r + ones_inc_s;
    density_calc_s = PROB_W'(ones_sum_s) << SHIFT;
  end

  // Ones counter, one bit wider than the tick counter so a full window fits.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ones_cnt_r <= {ONES_W{1'b0}};
    end else if (clear_s) begin
      ones_cnt_r <= ones_inc_s;
    end else begin
      ones_cnt_r <= ones_sum_s;
    end
  end

  // Registered outputs, decoded from the next state so they line up with it.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      busy_r          <= 1'b0;
      density_r       <= {PROB_W{1'b0}};
      density_valid_r <= 1'b0;
    end else begin
      busy_r          <= (state_next_s == ST_COUNT);
      density_valid_r <= (state_next_s == ST_REPORT);
      if (state_next_s == ST_REPORT) begin
        density_r <= density_calc_s;
      end else begin
        density_r <= density_r;
      end
    end
  end

  assign busy_o          = busy_r;
  assign density_o       = density_r;
  assign density_valid_o = density_valid_r;

endmodule

// File: tb/tb_bitstream_density_meter.sv
// Directed self-checking bench for bitstream_density_meter with a 16-tick window.
// Expected densities are pushed to a scoreboard when a window is started and
// popped when the DUT pulses density_valid_o.
module tb_bitstream_density_meter;

  logic        clk_i = 1'b0;
  logic        srst_i = 1'b1;
  logic        sample_tick_i = 1'b0;
  logic        bit_i = 1'b0;
  logic        start_i = 1'b0;
  logic        busy_o;
  logic [16:0] density_o;
  logic        density_valid_o;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int valid_cnt = 0;
  int sb[$];

  bitstream_density_meter #(
    .WINDOW_LOG2 (4),
    .PROB_W      (17)
  ) dut (
    .clk_i           (clk_i),
    .srst_i          (srst_i),
    .sample_tick_i   (sample_tick_i),
    .bit_i           (bit_i),
    .start_i         (start_i),
    .busy_o          (busy_o),
    .density_o       (density_o),
    .density_valid_o (density_valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Count valid pulses (value seen at the edge is the one held during the prior cycle).
  always @(posedge clk_i) begin
    if (density_valid_o === 1'b1) valid_cnt <= valid_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; returns at the next falling edge.
  task automatic step(input logic s, input logic t, input logic b);
    start_i       = s;
    sample_tick_i = t;
    bit_i         = b;
    @(negedge clk_i);
  endtask

  task automatic run_window(input string tag, input logic [15:0] bits,
                            input logic [15:0] gap_mask, input int restart_at);
    int v0;
    int e;
    sb.push_back($countones(bits) << 12);
    v0 = valid_cnt;
    step(1'b1, 1'b0, 1'b0);
    check({tag, "_busy"}, 32'(busy_o), 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (gap_mask[i]) step(1'b0, 1'b0, 1'b1);
      step(i == restart_at, 1'b1, bits[i]);
    end
    // One cycle after the final tick: report cycle.
    check({tag, "_valid"}, 32'(density_valid_o), 32'd1);
    check({tag, "_busy_rep"}, 32'(busy_o), 32'd0);
    e = sb.pop_front();
    if (density_valid_o === 1'b1) check({tag, "_density"}, 32'(density_o), 32'(e));
    step(1'b0, 1'b0, 1'b0);
    check({tag, "_valid_drop"}, 32'(density_valid_o), 32'd0);
    check({tag, "_hold"}, 32'(density_o), 32'(e));
    check({tag, "_pulses"}, 32'(valid_cnt), 32'(v0 + 1));
  endtask

  initial begin
    int v0;
    int e;
    // Reset wins over a simultaneous start.
    start_i = 1'b1;
    sample_tick_i = 1'b1;
    bit_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_valid", 32'(density_valid_o), 32'd0);
    check("rst_density", 32'(density_o), 32'd0);
    srst_i = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    check("idle_busy", 32'(busy_o), 32'd0);

`ifdef DENSITY_METER_CONTINUOUS_EN
    for (int w = 0; w < 3; w++) sb.push_back(16384);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 48; k++) begin
      step(1'b0, 1'b1, (k % 4) == 0);
      if ((k % 16) == 15) begin
        check("cont_valid", 32'(density_valid_o), 32'd1);
        check("cont_busy_rep", 32'(busy_o), 32'd0);
        if (density_valid_o === 1'b1) begin
          e = sb.pop_front();
          check("cont_density", 32'(density_o), 32'(e));
        end
      end else if ((k % 16) == 4) begin
        check("cont_busy", 32'(busy_o), 32'd1);
      end
    end
    srst_i = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    srst_i = 1'b0;
    check("cont_pulses", 32'(valid_cnt), 32'd3);
`else
    run_window("ones", 16'hFFFF, 16'h0000, -1);
    run_window("alt", 16'h5555, 16'h0000, -1);
    run_window("zeros", 16'h0000, 16'h0000, -1);
    run_window("five", 16'h1F00, 16'hFFFF, -1);

    // Abort mid-window: reset with start and a tick in the same cycle.
    v0 = valid_cnt;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1);
    srst_i = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    srst_i = 1'b0;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_valid", 32'(density_valid_o), 32'd0);
    check("abort_density", 32'(density_o), 32'd0);
    // Ticks without a start must not open a window.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1);
    check("no_start_busy", 32'(busy_o), 32'd0);
    check("no_start_pulses", 32'(valid_cnt), 32'(v0));

    run_window("after_rst", 16'h0007, 16'h0000, -1);
    run_window("restart", 16'hC3C3, 16'h0000, 10);
    check("sb_empty", 32'(sb.size()), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bitstream_density_meter.md
BITSTREAM_DENSITY_METER -- requirements
Module: bitstream_density_meter

Interface
REQ-001 SHALL have parameter WINDOW_LOG2, default 16, meaning a measurement window of 2**WINDOW_LOG2 sample ticks; legal range 1..16.
REQ-002 SHALL have parameter PROB_W, default 17, meaning the result width in probability units, where 2**16 means "always 1".
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port srst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port sample_tick_i, input, 1 bit: sample strobe that qualifies bit_i.
REQ-006 SHALL have port bit_i, input, 1 bit: measured bitstream (e.g. angle increment enable).
REQ-007 SHALL have port start_i, input, 1 bit: one-cycle request to begin a measurement.
REQ-008 SHALL have port busy_o, output, 1 bit: high while a window is open.
REQ-009 SHALL have port density_o, output, PROB_W bits: last measured probability of 1.
REQ-010 SHALL have port density_valid_o, output, 1 bit: one-cycle pulse when density_o updates.

Function
REQ-011 SHALL implement states IDLE, COUNT and REPORT.
REQ-012 IDLE: start_i=1 SHALL move to COUNT next cycle, clear tick_cnt and ones_cnt, and set busy_o=1.
REQ-013 COUNT: each cycle with sample_tick_i=1 SHALL increment tick_cnt and add bit_i to ones_cnt; bit_i without sample_tick_i SHALL be ignored.
REQ-014 COUNT: a sample tick with tick_cnt == 2**WINDOW_LOG2-1 SHALL be counted and SHALL move to REPORT on the next cycle.
REQ-015 ones_cnt SHALL be WINDOW_LOG2+1 bits wide and SHALL hold 2**WINDOW_LOG2 without overflow.
REQ-016 REPORT SHALL last one cycle: density_o = ones_cnt << (16-WINDOW_LOG2), zero-extended to PROB_W; density_valid_o=1; busy_o=0.
REQ-017 REPORT SHALL then go to IDLE unless the continuous mode of REQ-024 is compiled in.
REQ-018 Latency SHALL be exactly 1 cycle from the final counted tick to density_valid_o.
REQ-019 start_i during COUNT or REPORT SHALL be ignored and SHALL NOT restart the window.
REQ-020 density_o SHALL hold its value between reports.
REQ-021 Maximum density (all ones) SHALL be 2**16 exactly; minimum SHALL be 0.

Reset
REQ-022 srst_i SHALL force state=IDLE, tick_cnt=0, ones_cnt=0, busy_o=0, density_o=0 and density_valid_o=0 on the next edge.
REQ-023 srst_i asserted mid-window SHALL abort the measurement with no density_valid_o pulse; srst_i SHALL override start_i in the same cycle.

Configuration
REQ-024 Macro DENSITY_METER_CONTINUOUS_EN, when defined: REPORT SHALL go directly to COUNT with cleared counters, so windows run back-to-back with no lost tick. The tick coinciding with REPORT SHALL count toward the new window.
REQ-025 Macro DENSITY_METER_CONTINUOUS_EN, when undefined: each measurement SHALL require its own start_i.

Structure
REQ-026 Shared package bitstream_density_pkg SHALL hold the state enum, PROB_W default and FULL_SCALE = 2**16.
REQ-027 Sub-module tick_window_counter SHALL hold tick_cnt and a terminal-count flag, with inputs clear and tick; the FSM and ones_cnt SHALL stay in the top level.

Verification (WINDOW_LOG2=4, 16-tick window)
REQ-028 Start, then 16 ticks with bit_i=1 -> density_o=65536, one valid pulse, 1 cycle after the 16th tick.
REQ-029 Start, then 16 ticks alternating 1/0 -> density_o=32768; 16 ticks all 0 -> density_o=0.
REQ-030 Start, then 5 ones among 16 ticks, with extra bit_i=1 pulses on non-tick cycles -> density_o=20480.
REQ-031 srst_i after 8 ticks -> no valid pulse, busy_o=0, density_o=0; a new start then produces a correct result.
REQ-032 start_i re-asserted at tick 10 -> ignored; result and timing identical to no re-assert.
REQ-033 DENSITY_METER_CONTINUOUS_EN defined, constant 25% stream -> valid pulse every window with density_o=16384, no tick lost between windows.
